// File: rtl/core_bus_pkg.sv
// Shared types for the two-port core bus arbiter.
// Optional grant locking is enabled with CORE_BUS_ARB_LOCK_EN.
package core_bus_pkg;

  typedef logic [29:0] word_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    word_addr_t addr;
    logic       write;
    word_t      data_wr;
  } core_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  // Winner among pending ports; pref breaks a tie.
  function automatic logic arb_pick(
    input logic [1:0] pend,
    input logic       pref
  );
    logic g;
    g = 1'b0;
    unique case (1'b1)
      (pend == 2'b11): g = pref;
      (pend == 2'b10): g = 1'b1;
      default:         g = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/core_bus_req_slot.sv
// Per-port request holder: pending flag plus captured request.
// A new start in the same cycle as the clear is accepted.
module core_bus_req_slot
  import core_bus_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  logic      clr,
  input  core_req_t req_d,
  output logic      pending,
  output logic      accept,
  output core_req_t req_q
);

  assign accept = start & (~pending | clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      req_q   <= '0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        req_q   <= req_d;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-port arbiter in front of a single core-style bus master.
// Optional grant locking is enabled with CORE_BUS_ARB_LOCK_EN.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0][ADDR_W-1:0] s_addr,
  input  logic [1:0]             s_start,
  input  logic [1:0]             s_write,
  input  logic [1:0][DATA_W-1:0] s_data_wr,
`ifdef CORE_BUS_ARB_LOCK_EN
  input  logic [1:0]             s_lock,
`endif
  output logic [1:0][DATA_W-1:0] s_data_rd,
  output logic [1:0]             s_ready,
  output logic [ADDR_W-1:0]      m_addr,
  output logic                   m_start,
  output logic                   m_write,
  output logic [DATA_W-1:0]      m_data_wr,
  input  logic [DATA_W-1:0]      m_data_rd,
  input  logic                   m_ready,
  output logic                   busy
);

  arb_state_t state;
  arb_state_t state_d;

  logic [1:0] pending;
  logic [1:0] accept;
  logic [1:0] clr;
  core_req_t  req_q [2];

  logic g;
  logic g_sel;
  logic rr_ptr;
  logic rr_pref;
  logic pref;
  logic can_grant;
  logic done;
  logic grant_now;

  logic [1:0][DATA_W-1:0] rd_hold;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    core_req_t req_d;
    assign req_d = '{
      addr:    word_addr_t'(s_addr[i]),
      write:   s_write[i],
      data_wr: word_t'(s_data_wr[i])
    };
    assign clr[i] = done & (g == 1'(i));

    core_bus_req_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (s_start[i]),
      .clr     (clr[i]),
      .req_d   (req_d),
      .pending (pending[i]),
      .accept  (accept[i]),
      .req_q   (req_q[i])
    );
  end

  assign done      = (state == WAIT) & m_ready;
  assign rr_pref   = (ROUND_ROBIN != 0) ? rr_ptr : 1'b0;
  assign g_sel     = arb_pick(pending, pref);
  assign grant_now = (state == IDLE) & can_grant;

`ifdef CORE_BUS_ARB_LOCK_EN
  localparam int LOCK_WIN = 16;

  logic [1:0] lock_q;
  logic       cur_lock;
  logic       lock_act;
  logic       lock_port;
  logic [3:0] lock_cnt;

  // A held lock reserves the bus for its owner until the window lapses.
  assign pref      = lock_act ? lock_port : rr_pref;
  assign can_grant = lock_act ? pending[lock_port] : |pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= '0;
      cur_lock  <= 1'b0;
      lock_act  <= 1'b0;
      lock_port <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) lock_q[i] <= s_lock[i];
      end
      if (grant_now) begin
        cur_lock <= lock_q[g_sel];
        lock_act <= 1'b0;
      end else if (state == IDLE && lock_act) begin
        if (lock_cnt == 4'(LOCK_WIN - 1)) lock_act <= 1'b0;
        else lock_cnt <= lock_cnt + 4'd1;
      end
      if (done && cur_lock) begin
        lock_act  <= 1'b1;
        lock_port <= g;
        lock_cnt  <= '0;
      end
    end
  end
`else
  assign pref      = rr_pref;
  assign can_grant = |pending;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (can_grant) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_start = (state == ISSUE);
    busy    = (|pending) | (state != IDLE);
    for (int i = 0; i < 2; i++) begin
      s_ready[i]   = done & (g == 1'(i));
      s_data_rd[i] = s_ready[i] ? m_data_rd : rd_hold[i];
    end
  end

  // Bus-side request is frozen from ISSUE until completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g         <= 1'b0;
      rr_ptr    <= 1'b0;
      m_addr    <= '0;
      m_write   <= 1'b0;
      m_data_wr <= '0;
      rd_hold   <= '0;
    end else begin
      if (grant_now) begin
        g         <= g_sel;
        m_addr    <= ADDR_W'(req_q[g_sel].addr);
        m_write   <= req_q[g_sel].write;
        m_data_wr <= DATA_W'(req_q[g_sel].data_wr);
      end
      if (done) begin
        rr_ptr     <= ~g;
        rd_hold[g] <= m_data_rd;
      end
    end
  end

endmodule
